// File: rtl/rv_pkg.sv
// rv_pkg: types and constants shared by the fetch unit, its PC register and
// the immediate-extension stage downstream of decode.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // Major opcodes; the immediate-extension stage selects its format from these.
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b010_0011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b011_0011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b011_0111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b110_0111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b110_1111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b111_0011;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  // Instruction buffer payload handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: architectural fetch PC.
//   clk, rst_n   : clock, synchronous active-low reset (loads RESET_PC)
//   redirect     : load word-aligned redirect_pc (wins over advance)
//   redirect_pc  : redirect target, low two bits ignored
//   advance      : step to the next sequential word (wraps modulo 2^32)
//   pc           : current fetch PC (registered)
module pc_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;

  // Redirect mux ahead of the sequential increment.
  always_comb begin
    pc_d = pc;
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end else if (advance) begin
      pc_d = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= word_align(RESET_PC);
    end else begin
      pc <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry buffer.
//   clk, rst_n         : clock, synchronous active-low reset
//   imem_req/imem_addr : request and word address to instruction memory
//   imem_gnt           : memory accepts the request this cycle
//   imem_rvalid/rdata  : response data for the granted request
//   redirect_valid/pc  : control-flow change from execute
//   instr_valid/ready  : handshake with decode
//   instr/instr_pc     : buffered instruction and its address
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic            killed_q;
  logic            killed_d;
  logic            imem_req_d;
  logic            instr_valid_d;
  logic            capture;
  logic            grant;
  logic            handshake;
  logic [XLEN-1:0] pc;
  fetch_pkt_t      ibuf_q;

  // A grant only counts while a request is actually presented.
  assign grant     = imem_req & imem_gnt;
  assign handshake = instr_valid & instr_ready;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .advance     (handshake),
    .pc          (pc)
  );

  // Next-state, kill tracking and registered-output next values.
  // killed marks the one outstanding response as stale. While it is set in
  // REQ no new request is issued, so at most one response is ever in flight;
  // the stale response retires the flag when it arrives.
  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    capture  = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end

      FETCH_REQ: begin
        if (imem_rvalid && killed_q) begin
          killed_d = 1'b0;
        end
        if (redirect_valid) begin
          state_d = FETCH_REQ;
          if (grant) begin
            killed_d = 1'b1;
          end
        end else if (grant) begin
          state_d = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        if (imem_rvalid) begin
          killed_d = 1'b0;
          if (!killed_q && !redirect_valid) begin
            capture = 1'b1;
            state_d = FETCH_HOLD;
          end else begin
            state_d = FETCH_REQ;
          end
        end else if (redirect_valid) begin
          killed_d = 1'b1;
        end
      end

      FETCH_HOLD: begin
        if (redirect_valid || handshake) begin
          state_d = FETCH_REQ;
        end
      end

      default: begin
        state_d  = FETCH_IDLE;
        killed_d = 1'b0;
      end
    endcase

    imem_req_d    = (state_d == FETCH_REQ) && !killed_d;
    instr_valid_d = (state_d == FETCH_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      killed_q     <= 1'b0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      ibuf_q.pc    <= word_align(RESET_PC);
      ibuf_q.instr <= NOP;
    end else begin
      state_q     <= state_d;
      killed_q    <= killed_d;
      imem_req    <= imem_req_d;
      instr_valid <= instr_valid_d;
      // The PC cannot move between grant and an unkilled response.
      if (capture) begin
        ibuf_q.pc    <= pc;
        ibuf_q.instr <= imem_rdata;
      end
    end
  end

  assign imem_addr = pc;
  assign instr     = ibuf_q.instr;
  assign instr_pc  = ibuf_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with a transaction-level fetch model.
// The model tracks only the architectural PC (reset, +4 per consumed
// instruction, redirect target) and a memory whose data is a function of the
// address; every cycle the DUT outputs are checked against it.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RESET_PC0 = 32'h0000_0000;
  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // Second instance at the top of the address space, trivially fed.
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        tie1;
  logic        tie0;
  logic [31:0] rdata2;
  logic [31:0] zero32;

  fetch_unit #(.RESET_PC(RESET_PC0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  fetch_unit #(.RESET_PC(RESET_PC2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(tie1),
    .imem_rvalid(tie1), .imem_rdata(rdata2),
    .redirect_valid(tie0), .redirect_pc(zero32),
    .instr_valid(instr_valid2), .instr_ready(tie1),
    .instr(instr2), .instr_pc(instr_pc2)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus knobs: mode 0 random (pct), 1 always, 2 never.
  int unsigned gnt_mode, gnt_pct, ready_mode, ready_pct, redir_pct;
  int unsigned dly_min, dly_max;
  logic        rst_knob;
  logic        redir_shot;
  logic [31:0] redir_shot_pc;
  logic        ovr_en;
  logic [31:0] ovr_data;

  // Memory environment: one pending response.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_dly;

  // Architectural model.
  logic [31:0] m_pc;
  int          handshakes;
  logic        seen_bad;

  typedef struct {
    logic        rst_n, req, gnt, redir, valid, ready;
    logic [31:0] addr, rpc, instr, ipc;
  } snap_t;
  snap_t pv;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input int unsigned mode, input int unsigned pct);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return $urandom_range(99, 0) < pct;
  endfunction

  // One clock: apply the last edge to the model, check outputs, drive inputs.
  task automatic cyc();
    int r;
    @(negedge clk);
    if (!pv.rst_n) begin
      m_pc = RESET_PC0;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, RESET_PC0);
    end else begin
      if (pv.req && pv.gnt) begin
        chk("single_outstanding", 32'(pend), 32'd0);
        pend      = 1'b1;
        pend_addr = pv.addr;
        pend_dly  = int'($urandom_range(dly_max, dly_min));
      end
      if (pv.valid && pv.ready) handshakes++;
      if (pv.redir) m_pc = {pv.rpc[31:2], 2'b00};
      else if (pv.valid && pv.ready) m_pc = m_pc + 32'd4;

      if (imem_req) chk("fetch_addr", imem_addr, m_pc);
      if (instr_valid) begin
        chk("instr_pc", instr_pc, m_pc);
        chk("instr_data", instr, mem_f(m_pc));
      end
      if (pv.valid && (pv.ready || pv.redir))
        chk("valid_drop", 32'(instr_valid), 32'd0);
      if (pv.valid && !pv.ready && !pv.redir) begin
        chk("valid_hold", 32'(instr_valid), 32'd1);
        chk("instr_hold", instr, pv.instr);
        chk("instr_pc_hold", instr_pc, pv.ipc);
      end
      if (pv.req && !pv.gnt && !pv.redir) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", imem_addr, pv.addr);
      end
    end
    if (instr_valid && instr == 32'hDEAD_BEEF) seen_bad = 1'b1;

    rst_n       = rst_knob;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pend_dly == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ovr_en ? ovr_data : mem_f(pend_addr);
        ovr_en      = 1'b0;
        pend        = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    imem_gnt       = pick(gnt_mode, gnt_pct);
    instr_ready    = pick(ready_mode, ready_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (redir_shot) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_shot_pc;
      redir_shot     = 1'b0;
    end else if (redir_pct > 0 && $urandom_range(99, 0) < redir_pct) begin
      redirect_valid = 1'b1;
      r = int'($urandom_range(3, 0));
      if (r == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
      else        redirect_pc = 32'($urandom_range(1023, 0));
    end

    pv.rst_n = rst_n;        pv.req   = imem_req;    pv.gnt   = imem_gnt;
    pv.redir = redirect_valid; pv.valid = instr_valid; pv.ready = instr_ready;
    pv.addr  = imem_addr;    pv.rpc   = redirect_pc; pv.instr = instr;
    pv.ipc   = instr_pc;
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!instr_valid && n < max_cyc) begin
      cyc();
      n++;
    end
    chk({name, "_valid_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!imem_req && n < max_cyc) begin
      cyc();
      n++;
    end
    chk({name, "_req_timeout"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tie1 = 1'b1; tie0 = 1'b0; rdata2 = 32'h0000_0013; zero32 = 32'h0;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    gnt_mode = 1; gnt_pct = 50; ready_mode = 1; ready_pct = 50; redir_pct = 0;
    dly_min = 0; dly_max = 0; rst_knob = 1'b0; redir_shot = 1'b0;
    redir_shot_pc = 32'h0; ovr_en = 1'b0; ovr_data = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; pend_dly = 0;
    m_pc = RESET_PC0; handshakes = 0; seen_bad = 1'b0;
    pv = '{default: '0};

    // Back-to-back fetch with immediate grant and response.
    cyc(); cyc();
    chk("dut2_rst_pc", instr_pc2, RESET_PC2);
    chk("dut2_rst_req", 32'(imem_req2), 32'd0);
    rst_knob = 1'b1;
    cyc();
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c % 3 == 0) begin
        chk("seq_valid", 32'(instr_valid), 32'd1);
        chk("seq_pc", instr_pc, 32'((c / 3 - 1) * 4));
        chk("seq_instr", instr, 32'((c / 3 - 1) * 4) ^ 32'hA5A5_0000);
      end else begin
        chk("seq_idle", 32'(instr_valid), 32'd0);
      end
      if (c == 1) begin
        chk("wrap_req0", 32'(imem_req2), 32'd1);
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
      end
      if (c == 3) begin
        chk("wrap_valid", 32'(instr_valid2), 32'd1);
        chk("wrap_ipc", instr_pc2, 32'hFFFF_FFFC);
        chk("wrap_instr", instr2, 32'h0000_0013);
      end
      if (c == 4) begin
        chk("wrap_req1", 32'(imem_req2), 32'd1);
        chk("wrap_addr1", imem_addr2, 32'h0000_0000);
      end
    end

    // Decode stalls for five cycles with an instruction held.
    ready_mode = 2;
    cyc();
    wait_valid(20, "stall");
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", instr_pc, 32'h0000_000C);
      chk("stall_instr", instr, 32'hA5A5_000C);
      chk("stall_noreq", 32'(imem_req), 32'd0);
    end
    ready_mode = 1;
    cyc();
    wait_req(10, "stall_release");
    chk("stall_next_addr", imem_addr, 32'h0000_0010);

    // Redirect while waiting; the stale response carries a poison word.
    dly_min = 1; dly_max = 1;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    redir_shot = 1'b1; redir_shot_pc = 32'h0000_0103;
    cyc(); cyc(); cyc();
    chk("kill_req", 32'(imem_req), 32'd1);
    chk("kill_addr", imem_addr, 32'h0000_0100);
    dly_min = 0; dly_max = 0;
    wait_valid(20, "kill");
    chk("kill_pc", instr_pc, 32'h0000_0100);
    chk("kill_instr", instr, 32'hA5A5_0100);

    // Reset while a response is outstanding; it lands after release.
    dly_min = 4; dly_max = 4;
    wait_req(10, "rst_mid");
    chk("rst_mid_addr", imem_addr, 32'h0000_0104);
    cyc();
    rst_knob = 1'b0;
    cyc();
    rst_knob = 1'b1; gnt_mode = 2;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("nognt_req", 32'(imem_req), 32'd1);
      chk("nognt_addr", imem_addr, 32'h0000_0000);
      chk("nognt_valid", 32'(instr_valid), 32'd0);
    end
    gnt_mode = 1; dly_min = 0; dly_max = 0;
    wait_valid(20, "rst_mid");
    chk("rst_first_pc", instr_pc, RESET_PC0);
    chk("rst_first_instr", instr, 32'hA5A5_0000);

    // Randomized traffic, redirects landing in every state.
    for (int blk = 0; blk < 8; blk++) begin
      gnt_mode   = 0; gnt_pct   = 20 + $urandom_range(80, 0);
      ready_mode = 0; ready_pct = 20 + $urandom_range(80, 0);
      dly_min    = 0; dly_max   = $urandom_range(3, 0);
      redir_pct  = (blk % 2 == 1) ? 8 : 3;
      for (int i = 0; i < 400; i++) cyc();
    end
    redir_pct = 0; gnt_mode = 1; ready_mode = 1;
    for (int i = 0; i < 10; i++) cyc();

    chk("progress", 32'(handshakes > 100), 32'd1);
    chk("poison_never_valid", 32'(seen_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
